// File: rtl/eth_measurer_reader.sv
// Consumer of the measurer timing FIFO: pops {pong, ping} round-trip entries,
// accumulates per-direction statistics and hands software a coherent copy on request.
module eth_measurer_reader #(
  parameter int CNT_WIDTH = 32,
  parameter int SUM_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  input  logic [63:0]          fifo_out,
  input  logic                 enable,
  input  logic                 snapshot_req,
  input  logic                 clear_req,
  output logic [CNT_WIDTH-1:0] snap_samples,
  output logic [CNT_WIDTH-1:0] snap_ping_lost,
  output logic [CNT_WIDTH-1:0] snap_pong_lost,
  output logic [31:0]          snap_ping_min,
  output logic [31:0]          snap_ping_max,
  output logic [31:0]          snap_pong_min,
  output logic [31:0]          snap_pong_max,
  output logic [SUM_WIDTH-1:0] snap_ping_sum,
  output logic [SUM_WIDTH-1:0] snap_pong_sum,
  output logic [63:0]          snap_last,
  output logic                 snap_done
);

  localparam logic [31:0] LOST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, POP, LATCH, UPDATE} state_t;

  state_t state_reg;
  logic [63:0] entry_reg;

  // Live accumulators and their post-UPDATE values
  logic [CNT_WIDTH-1:0] samples_reg, samples_next;
  logic [CNT_WIDTH-1:0] ping_lost_reg, ping_lost_next;
  logic [CNT_WIDTH-1:0] pong_lost_reg, pong_lost_next;
  logic [31:0]          ping_min_reg, ping_min_next;
  logic [31:0]          ping_max_reg, ping_max_next;
  logic [31:0]          pong_min_reg, pong_min_next;
  logic [31:0]          pong_max_reg, pong_max_next;
  logic [SUM_WIDTH-1:0] ping_sum_reg, ping_sum_next;
  logic [SUM_WIDTH-1:0] pong_sum_reg, pong_sum_next;
  logic [63:0]          last_reg, last_next;

  logic [31:0] ping_val;
  logic [31:0] pong_val;

  assign ping_val = entry_reg[31:0];
  assign pong_val = entry_reg[63:32];

  // Pop strobe comes straight from the state register: no input-to-output path
  assign fifo_read = (state_reg == POP);

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  function automatic logic [SUM_WIDTH-1:0] sum_add(input logic [SUM_WIDTH-1:0] s,
                                                    input logic [31:0] v);
    logic [SUM_WIDTH:0] t;
    t = {1'b0, s} + {{(SUM_WIDTH - 31){1'b0}}, v};
    return t[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : t[SUM_WIDTH-1:0];
  endfunction

  // Sequencer: one entry per IDLE -> POP -> LATCH -> UPDATE round
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      entry_reg <= '0;
    end else begin
      case (state_reg)
        IDLE:    if (enable && !fifo_empty) state_reg <= POP;
        POP:     state_reg <= LATCH;
        LATCH: begin
          entry_reg <= fifo_out;
          state_reg <= UPDATE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Classify the latched entry and compute the accumulators it produces
  always_comb begin
    samples_next   = samples_reg;
    ping_lost_next = ping_lost_reg;
    pong_lost_next = pong_lost_reg;
    ping_min_next  = ping_min_reg;
    ping_max_next  = ping_max_reg;
    pong_min_next  = pong_min_reg;
    pong_max_next  = pong_max_reg;
    ping_sum_next  = ping_sum_reg;
    pong_sum_next  = pong_sum_reg;
    last_next      = last_reg;
    if (state_reg == UPDATE) begin
      samples_next = cnt_inc(samples_reg);
      last_next    = entry_reg;
      if (ping_val == LOST) begin
        ping_lost_next = cnt_inc(ping_lost_reg);
      end else begin
        if (ping_val < ping_min_reg) ping_min_next = ping_val;
        if (ping_val > ping_max_reg) ping_max_next = ping_val;
        ping_sum_next = sum_add(ping_sum_reg, ping_val);
        if (pong_val == LOST) begin
          pong_lost_next = cnt_inc(pong_lost_reg);
        end else begin
          if (pong_val < pong_min_reg) pong_min_next = pong_val;
          if (pong_val > pong_max_reg) pong_max_next = pong_val;
          pong_sum_next = sum_add(pong_sum_reg, pong_val);
        end
      end
    end
  end

  // Live statistics: clear overrides any same-cycle update
  always_ff @(posedge clk) begin
    if (rst || clear_req) begin
      samples_reg   <= '0;
      ping_lost_reg <= '0;
      pong_lost_reg <= '0;
      ping_min_reg  <= LOST;
      ping_max_reg  <= '0;
      pong_min_reg  <= LOST;
      pong_max_reg  <= '0;
      ping_sum_reg  <= '0;
      pong_sum_reg  <= '0;
      last_reg      <= '0;
    end else begin
      samples_reg   <= samples_next;
      ping_lost_reg <= ping_lost_next;
      pong_lost_reg <= pong_lost_next;
      ping_min_reg  <= ping_min_next;
      ping_max_reg  <= ping_max_next;
      pong_min_reg  <= pong_min_next;
      pong_max_reg  <= pong_max_next;
      ping_sum_reg  <= ping_sum_next;
      pong_sum_reg  <= pong_sum_next;
      last_reg      <= last_next;
    end
  end

  // Snapshot copy: takes the post-update, pre-clear values so software sees a coherent set
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_samples   <= '0;
      snap_ping_lost <= '0;
      snap_pong_lost <= '0;
      snap_ping_min  <= LOST;
      snap_ping_max  <= '0;
      snap_pong_min  <= LOST;
      snap_pong_max  <= '0;
      snap_ping_sum  <= '0;
      snap_pong_sum  <= '0;
      snap_last      <= '0;
      snap_done      <= 1'b0;
    end else begin
      snap_done <= snapshot_req;
      if (snapshot_req) begin
        snap_samples   <= samples_next;
        snap_ping_lost <= ping_lost_next;
        snap_pong_lost <= pong_lost_next;
        snap_ping_min  <= ping_min_next;
        snap_ping_max  <= ping_max_next;
        snap_pong_min  <= pong_min_next;
        snap_pong_max  <= pong_max_next;
        snap_ping_sum  <= ping_sum_next;
        snap_pong_sum  <= pong_sum_next;
        snap_last      <= last_next;
      end
    end
  end

endmodule

// File: tb/tb_eth_measurer_reader.sv
// Directed bench for eth_measurer_reader: table of entry batches plus hand-timed
// sequences for saturation, same-cycle snapshot/clear, enable gating and reset.
module tb_eth_measurer_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_read;
  logic        s_fifo_read;
  logic [63:0] fifo_out = '0;
  logic        enable;
  logic        snapshot_req;
  logic        clear_req;

  logic [31:0] snap_samples, snap_ping_lost, snap_pong_lost;
  logic [31:0] snap_ping_min, snap_ping_max, snap_pong_min, snap_pong_max;
  logic [47:0] snap_ping_sum, snap_pong_sum;
  logic [63:0] snap_last;
  logic        snap_done;

  // Narrow instance used to reach counter and sum saturation quickly
  logic [1:0]  s_samples, s_ping_lost, s_pong_lost;
  logic [31:0] s_ping_min, s_ping_max, s_pong_min, s_pong_max;
  logic [32:0] s_ping_sum, s_pong_sum;
  logic [63:0] s_last;
  logic        s_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  eth_measurer_reader u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .fifo_out(fifo_out), .enable(enable), .snapshot_req(snapshot_req),
    .clear_req(clear_req), .snap_samples(snap_samples), .snap_ping_lost(snap_ping_lost),
    .snap_pong_lost(snap_pong_lost), .snap_ping_min(snap_ping_min),
    .snap_ping_max(snap_ping_max), .snap_pong_min(snap_pong_min),
    .snap_pong_max(snap_pong_max), .snap_ping_sum(snap_ping_sum),
    .snap_pong_sum(snap_pong_sum), .snap_last(snap_last), .snap_done(snap_done)
  );

  eth_measurer_reader #(.CNT_WIDTH(2), .SUM_WIDTH(33)) u_sat (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read(s_fifo_read),
    .fifo_out(fifo_out), .enable(enable), .snapshot_req(snapshot_req),
    .clear_req(clear_req), .snap_samples(s_samples), .snap_ping_lost(s_ping_lost),
    .snap_pong_lost(s_pong_lost), .snap_ping_min(s_ping_min),
    .snap_ping_max(s_ping_max), .snap_pong_min(s_pong_min),
    .snap_pong_max(s_pong_max), .snap_ping_sum(s_ping_sum),
    .snap_pong_sum(s_pong_sum), .snap_last(s_last), .snap_done(s_done)
  );

  // FIFO model: data valid the cycle after the pop strobe
  logic [63:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_out <= fifo_mem[rd_ptr % 64];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Pop-strobe monitor: count, spacing, pops on empty, and agreement of both instances
  int cyc = 0;
  int rd_count = 0;
  int last_rd = -100;
  int spacing_err = 0;
  int empty_rd_err = 0;
  int sync_err = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read !== s_fifo_read) sync_err <= sync_err + 1;
    if (fifo_read) begin
      rd_count <= rd_count + 1;
      last_rd  <= cyc;
      if (cyc - last_rd < 4) spacing_err <= spacing_err + 1;
      if (fifo_empty) empty_rd_err <= empty_rd_err + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] e);
    fifo_mem[wr_ptr % 64] = e;
    wr_ptr++;
  endtask

  task automatic clear_pulse();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with snap_* settled
  task automatic snap();
    snapshot_req = 1'b1;
    @(negedge clk);
    snapshot_req = 1'b0;
    chk("snap_done_pulse", 64'(snap_done), 64'd1);
    @(negedge clk);
    chk("snap_done_drop", 64'(snap_done), 64'd0);
  endtask

  typedef struct {
    int          n;
    logic [63:0] e0, e1, e2;
    logic [63:0] samples, ping_lost, pong_lost;
    logic [63:0] ping_min, ping_max, pong_min, pong_max;
    logic [63:0] ping_sum, pong_sum, last;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int rd0;

    // {n, entries, samples, ping_lost, pong_lost, ping min/max, pong min/max, sums, last}
    vecs[0] = '{1, 64'h0000_00C8_0000_0064, 64'h0, 64'h0,
                1, 0, 0, 100, 100, 200, 200, 100, 200, 64'h0000_00C8_0000_0064};
    vecs[1] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_0032, 64'h0,
                2, 1, 1, 50, 50, 32'hFFFF_FFFF, 0, 50, 0, 64'hFFFF_FFFF_0000_0032};
    vecs[2] = '{3, 64'h0000_0001_0000_001E, 64'h0000_0002_0000_000A, 64'h0000_0003_0000_0014,
                3, 0, 0, 10, 30, 1, 3, 60, 6, 64'h0000_0003_0000_0014};
    vecs[3] = '{2, 64'h0, 64'hFFFF_FFFE_FFFF_FFFE, 64'h0,
                2, 0, 0, 0, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                64'hFFFF_FFFE_FFFF_FFFE};

    rst = 1'b1; enable = 1'b1; snapshot_req = 1'b0; clear_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fifo_read", 64'(fifo_read), 64'd0);
    chk("rst_samples", 64'(snap_samples), 64'd0);
    chk("rst_ping_lost", 64'(snap_ping_lost), 64'd0);
    chk("rst_pong_lost", 64'(snap_pong_lost), 64'd0);
    chk("rst_ping_min", 64'(snap_ping_min), 64'hFFFF_FFFF);
    chk("rst_ping_max", 64'(snap_ping_max), 64'd0);
    chk("rst_pong_min", 64'(snap_pong_min), 64'hFFFF_FFFF);
    chk("rst_pong_max", 64'(snap_pong_max), 64'd0);
    chk("rst_ping_sum", 64'(snap_ping_sum), 64'd0);
    chk("rst_pong_sum", 64'(snap_pong_sum), 64'd0);
    chk("rst_last", snap_last, 64'd0);
    chk("rst_snap_done", 64'(snap_done), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_empty_no_read", 64'(rd_count), 64'd0);
    $display("reset sequence done");

    // Table-driven batches, each from freshly cleared statistics
    for (int v = 0; v < 4; v++) begin
      clear_pulse();
      rd0 = rd_count;
      push(vecs[v].e0);
      if (vecs[v].n > 1) push(vecs[v].e1);
      if (vecs[v].n > 2) push(vecs[v].e2);
      repeat (4 * vecs[v].n) @(negedge clk);
      snap();
      chk($sformatf("v%0d_reads", v), 64'(rd_count - rd0), 64'(vecs[v].n));
      chk($sformatf("v%0d_samples", v), 64'(snap_samples), vecs[v].samples);
      chk($sformatf("v%0d_ping_lost", v), 64'(snap_ping_lost), vecs[v].ping_lost);
      chk($sformatf("v%0d_pong_lost", v), 64'(snap_pong_lost), vecs[v].pong_lost);
      chk($sformatf("v%0d_ping_min", v), 64'(snap_ping_min), vecs[v].ping_min);
      chk($sformatf("v%0d_ping_max", v), 64'(snap_ping_max), vecs[v].ping_max);
      chk($sformatf("v%0d_pong_min", v), 64'(snap_pong_min), vecs[v].pong_min);
      chk($sformatf("v%0d_pong_max", v), 64'(snap_pong_max), vecs[v].pong_max);
      chk($sformatf("v%0d_ping_sum", v), 64'(snap_ping_sum), vecs[v].ping_sum);
      chk($sformatf("v%0d_pong_sum", v), 64'(snap_pong_sum), vecs[v].pong_sum);
      chk($sformatf("v%0d_last", v), snap_last, vecs[v].last);
      $display("vector %0d: %0d entries, samples=%0d ping_sum=%0d", v, vecs[v].n,
               snap_samples, snap_ping_sum);
    end

    // Saturation: narrow instance caps counters at 3 and sums at 2^33-1
    clear_pulse();
    push(64'h0000_0001_FFFF_FFFE);
    push(64'h0000_0001_FFFF_FFFE);
    push(64'h0000_0001_0000_0005);
    push(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (16) @(negedge clk);
    snap();
    chk("sat_wide_samples", 64'(snap_samples), 64'd4);
    chk("sat_wide_ping_sum", 64'(snap_ping_sum), 64'h2_0000_0001);
    chk("sat_narrow_samples", 64'(s_samples), 64'd3);
    chk("sat_narrow_ping_sum", 64'(s_ping_sum), 64'h1_FFFF_FFFF);
    chk("sat_narrow_pong_sum", 64'(s_pong_sum), 64'd3);
    chk("sat_narrow_ping_lost", 64'(s_ping_lost), 64'd1);
    $display("saturation sequence: wide samples=%0d narrow samples=%0d", snap_samples, s_samples);

    // Snapshot and clear in the UPDATE cycle of ping=7
    clear_pulse();
    push(64'h0000_0008_0000_0007);
    repeat (3) @(negedge clk);
    snapshot_req = 1'b1; clear_req = 1'b1;
    @(negedge clk);
    snapshot_req = 1'b0; clear_req = 1'b0;
    chk("sc_snap_done", 64'(snap_done), 64'd1);
    chk("sc_samples", 64'(snap_samples), 64'd1);
    chk("sc_ping_min", 64'(snap_ping_min), 64'd7);
    chk("sc_ping_sum", 64'(snap_ping_sum), 64'd7);
    chk("sc_pong_max", 64'(snap_pong_max), 64'd8);
    chk("sc_last", snap_last, 64'h0000_0008_0000_0007);
    @(negedge clk);
    snap();
    chk("sc_after_samples", 64'(snap_samples), 64'd0);
    chk("sc_after_ping_min", 64'(snap_ping_min), 64'hFFFF_FFFF);
    chk("sc_after_last", snap_last, 64'd0);
    $display("snapshot+clear sequence: first snapshot ping=7, then samples=%0d", snap_samples);

    // Clear alone in the UPDATE cycle: entry discarded
    push(64'h0000_0008_0000_0009);
    repeat (3) @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (2) @(negedge clk);
    snap();
    chk("cu_samples", 64'(snap_samples), 64'd0);
    chk("cu_ping_max", 64'(snap_ping_max), 64'd0);
    $display("clear-during-update sequence: samples=%0d", snap_samples);

    // enable gating with a non-empty FIFO, then a single-cycle enable
    enable = 1'b0;
    rd0 = rd_count;
    push(64'h0000_0002_0000_0001);
    push(64'h0000_0004_0000_0003);
    repeat (8) @(negedge clk);
    chk("en0_no_read", 64'(rd_count - rd0), 64'd0);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    chk("en_pulse_one_read", 64'(rd_count - rd0), 64'd1);
    snap();
    chk("en_pulse_samples", 64'(snap_samples), 64'd1);
    chk("en_pulse_ping_sum", 64'(snap_ping_sum), 64'd1);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    chk("en_resume_samples", 64'(snap_samples), 64'd2);
    chk("en_resume_ping_sum", 64'(snap_ping_sum), 64'd4);
    chk("en_resume_pong_sum", 64'(snap_pong_sum), 64'd6);
    $display("enable sequence: samples=%0d reads=%0d", snap_samples, rd_count - rd0);

    // Reset while the entry sits in LATCH: it is popped but never counted
    push(64'h0000_0006_0000_0005);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rl_fifo_read", 64'(fifo_read), 64'd0);
    chk("rl_snap_samples", 64'(snap_samples), 64'd0);
    chk("rl_snap_ping_min", 64'(snap_ping_min), 64'hFFFF_FFFF);
    chk("rl_snap_pong_sum", 64'(snap_pong_sum), 64'd0);
    chk("rl_snap_last", snap_last, 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    snap();
    chk("rl_after_samples", 64'(snap_samples), 64'd0);
    chk("rl_after_ping_sum", 64'(snap_ping_sum), 64'd0);
    chk("rl_fifo_drained", 64'(fifo_empty), 64'd1);
    $display("reset-in-latch sequence: samples=%0d", snap_samples);

    chk("read_spacing_errors", 64'(spacing_err), 64'd0);
    chk("read_on_empty_errors", 64'(empty_rd_err), 64'd0);
    chk("instance_read_sync_errors", 64'(sync_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
